// File: rtl/wb_pkg.sv
// wb_pkg: shared register-file widths and the writeback request type
package wb_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of ALU writeback requests
// clk/rst_n: clock, sync active-low reset; push/push_data: enqueue;
// pop: dequeue head; head: oldest entry; count: entries held
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_req_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= push_data;
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and load results onto one register-file write port
// alu_*: ALU result channel (buffered); mem_*: load-data channel (always accepted, top priority)
// issue_load/issue_rd: marks a load outstanding; wr_*: registered write port; pending: outstanding loads
import wb_pkg::*;

module writeback_unit #(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic [NUM_REGS-1:0]   pending
);
  localparam int CW = $clog2(ALU_FIFO_DEPTH+1);
  logic alu_fire, mem_fire, fifo_empty, push, pop, wr_valid;
  logic [CW-1:0] count;
  wb_req_t head, alu_req, mem_req, wr_req;
  logic wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  assign mem_ready = rst_n;
  assign alu_ready = rst_n && (count < CW'(ALU_FIFO_DEPTH));
  always_comb begin
    mem_fire   = mem_valid && mem_ready;
    alu_fire   = alu_valid && alu_ready;
    fifo_empty = count == '0;
    alu_req    = '{rd: alu_rd, data: alu_data};
    mem_req    = '{rd: mem_rd, data: mem_data};
    // Loads win; otherwise the oldest buffered ALU result, else bypass a fresh one.
    pop        = !mem_fire && !fifo_empty;
    push       = alu_fire && (mem_fire || !fifo_empty);
    wr_req     = mem_fire ? mem_req : (!fifo_empty ? head : alu_req);
    wr_valid   = mem_fire || !fifo_empty || alu_fire;
    wr_en_d    = wr_valid && wr_req.rd != '0;
    wr_addr_d  = wr_en_d ? wr_req.rd : wr_addr_q;
    wr_data_d  = wr_en_d ? wr_req.data : wr_data_q;
    pending_d  = pending_q;
    if (mem_fire) pending_d[mem_rd] = 1'b0;
    if (issue_load) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end
  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (alu_req),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter ALU_FIFO_DEPTH, default 2, meaning ALU result buffer entries (legal: 2, 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in 64, alu_ready out 1: ALU result channel, transfer when valid&&ready.
REQ-005 SHALL have ports mem_valid in 1, mem_rd in 5, mem_data in 64, mem_ready out 1: load-data channel, transfer when valid&&ready.
REQ-006 SHALL have ports issue_load in 1, issue_rd in 5: a load to issue_rd was issued this cycle.
REQ-007 SHALL have ports wr_en out 1, wr_addr out 5, wr_data out 64: register-file write port (regwrite, register3, datain).
REQ-008 SHALL have port pending out 32: bit i high = load outstanding to register i.

Function
REQ-009 SHALL perform at most one register-file write per cycle; wr_en, wr_addr, wr_data registered.
REQ-010 SHALL drive mem_ready=1 whenever rst_n=1; a mem transfer always wins the write port that cycle.
REQ-011 SHALL drive alu_ready = (FIFO count < ALU_FIFO_DEPTH), combinational from registered count.
REQ-012 SHALL, in a cycle with no mem transfer, write the FIFO head; if FIFO empty, write an ALU result accepted that same cycle directly (bypass).
REQ-013 SHALL push an accepted ALU result into the FIFO when it is not written that cycle; simultaneous push and pop SHALL keep count unchanged.
REQ-014 SHALL preserve ALU result order; write latency = 1 cycle from acceptance with no mem contention, else 1 + cycles of mem transfers ahead of it.
REQ-015 SHALL complete the handshake for any result with rd=0 but keep wr_en=0 that cycle (x0 never written).
REQ-016 SHALL set pending[issue_rd] on issue_load when issue_rd!=0; pending[0] SHALL always read 0.
REQ-017 SHALL clear pending[mem_rd] on a mem transfer; same-cycle set and clear of one register SHALL leave the bit set.
REQ-018 SHALL NOT change pending on ALU writes; issue_load to an already-pending register keeps it set.
REQ-019 SHALL drive wr_en=0 in any cycle with nothing to write; wr_addr/wr_data then hold their last values.
REQ-020 SHALL tolerate alu_valid dropping without transfer; only accepted data affects state.

Reset
REQ-021 SHALL, on rising clk with rst_n=0: FIFO empty, pending=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-022 SHALL hold alu_ready=0 and mem_ready=0 while rst_n=0.
REQ-023 SHALL discard buffered ALU results and pending bits on reset mid-operation; first write possible the cycle after rst_n returns high.

Structure
REQ-024 SHALL take XLEN=64, REG_ADDR_W=5, NUM_REGS=32 and typedef wb_req_t {rd, data} from shared package wb_pkg.
REQ-025 SHALL implement the ALU buffer as sub-module wb_fifo (parameterised depth, push/pop/count/head), instantiated once.

Verification
REQ-026 SHALL cover: reset, then ALU rd=5 data=0x1234 alone -> next cycle wr_en=1, wr_addr=5, wr_data=0x1234; alu_ready=1 throughout.
REQ-027 SHALL cover: ALU rd=3 data=0xA and mem rd=7 data=0xB same cycle -> cycle+1 writes r7=0xB, cycle+2 writes r3=0xA.
REQ-028 SHALL cover: mem_valid held 3 cycles with ALU valid every cycle, depth 2 -> alu_ready low after 2 buffered, ALU writes drain in order after mem ends, no loss.
REQ-029 SHALL cover: issue_load rd=9, later mem rd=9 -> pending[9] 1 until the mem transfer cycle, then 0; issue_load rd=0 -> pending stays 0.
REQ-030 SHALL cover: same-cycle issue_load rd=4 and mem rd=4 -> pending[4]=1; ALU rd=0 data=0xFF -> wr_en stays 0.
REQ-031 SHALL cover: rst_n low for 1 cycle with 2 ALU entries buffered -> no further writes, pending=0, alu_ready=1 the cycle after release.
